// File: rtl/reg_display_pkg.sv
// Shared types and constants for the register-file viewer.
// Segment patterns are active-high with bit 0 = segment a through bit 6 = segment g.
package reg_display_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/reg_display_seg7_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_decode
    import reg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_pat
);

    always_comb begin
        seg_pat = HEX_SEG[nibble];
    end

endmodule

// File: rtl/reg_display.sv
// Register-file viewer: selects a processor register (manual or auto-scan), latches
// its value once per display frame and multiplexes it onto eight 7-segment digits.
//
// state  | meaning
// MANUAL | reg_out_id follows sel_id with one cycle of latency, hold timer idle
// AUTO   | reg_out_id advances every SCAN_HOLD cycles, wrapping 31 -> 0
module reg_display
    import reg_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int SCAN_HOLD      = 50000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  sel_id,
    input  logic        auto_en,
    input  logic [31:0] reg_out_data,
    output logic [4:0]  reg_out_id,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an
);

    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
    localparam int DIG_W  = $clog2(NUM_DIGITS);

    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic              POL       = (SEG_ACTIVE_LOW != 0);

    mode_e              state;
    mode_e              next_state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [REF_W-1:0]   ref_cnt;
    logic [DIG_W-1:0]   dig;
    logic [31:0]        shadow;
    logic               ref_last;
    logic               frame_end;
    logic [3:0]         nibble;
    logic [6:0]         seg_pat;
    logic [7:0]         an_onehot;
    logic               dp_on;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= MANUAL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (auto_en) begin
            next_state = AUTO;
        end else begin
            next_state = MANUAL;
        end
    end

    // The edge that enters AUTO only clears the hold timer; scanning resumes from
    // whatever register was already selected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_out_id <= '0;
            hold_cnt   <= '0;
        end else if (next_state == MANUAL) begin
            reg_out_id <= sel_id;
            hold_cnt   <= '0;
        end else if (state == MANUAL) begin
            hold_cnt   <= '0;
        end else if (hold_cnt == HOLD_LAST) begin
            reg_out_id <= reg_out_id + 5'd1;
            hold_cnt   <= '0;
        end else begin
            hold_cnt   <= hold_cnt + 1'b1;
        end
    end

    assign ref_last  = (ref_cnt == REF_LAST);
    assign frame_end = ref_last && (dig == DIG_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_cnt <= '0;
            dig     <= '0;
            shadow  <= '0;
        end else begin
            if (ref_last) begin
                ref_cnt <= '0;
                dig     <= dig + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            if (frame_end) begin
                shadow <= reg_out_data;
            end
        end
    end

    assign nibble = shadow[{dig, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .nibble  (nibble),
        .seg_pat (seg_pat)
    );

    always_comb begin
        an_onehot = 8'b1 << dig;
        dp_on     = (dig == DIG_LAST) && (state == AUTO);
    end

    // Polarity is applied at the output register so the pins are glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg <= HEX_SEG[0] ^ {7{POL}};
            an  <= 8'b0000_0001 ^ {8{POL}};
            dp  <= POL;
        end else begin
            seg <= seg_pat ^ {7{POL}};
            an  <= an_onehot ^ {8{POL}};
            dp  <= dp_on ^ POL;
        end
    end

endmodule

// File: tb/tb_reg_display.sv
// Randomized bench for reg_display against a cycle-count based reference model.
module tb_reg_display;

    localparam int RD = 4;
    localparam int SH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  sel_id;
    logic        auto_en;
    logic [31:0] reg_out_data;
    logic [4:0]  reg_out_id;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    logic [31:0] regs [32];
    logic [6:0]  hex_tbl [16];

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset, selected register, scan bookkeeping, latched frame value
    int          m_edges;
    int          m_id;
    int          m_base;
    int          m_age;
    bit          m_auto;
    logic [31:0] m_shadow;

    assign reg_out_data = regs[reg_out_id];

    always #5 clock = ~clock;

    reg_display #(
        .REFRESH_DIV    (RD),
        .SCAN_HOLD      (SH),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sel_id       (sel_id),
        .auto_en      (auto_en),
        .reg_out_data (reg_out_data),
        .reg_out_id   (reg_out_id),
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges  = 0;
        m_id     = 0;
        m_base   = 0;
        m_age    = 0;
        m_auto   = 1'b0;
        m_shadow = '0;
    endtask

    // One clock edge: outputs after the edge show the digit and frame value held before it.
    task automatic step();
        int         dig;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clock);
        dig   = (m_edges / RD) % 8;
        e_an  = ~(8'b1 << dig);
        e_seg = ~hex_tbl[m_shadow[4*dig +: 4]];
        e_dp  = !(dig == 7 && m_auto);
        if ((m_edges % RD) == RD - 1 && dig == 7) m_shadow = regs[m_id];
        if (!auto_en) begin
            m_id = sel_id;
        end else if (!m_auto) begin
            m_base = m_id;
            m_age  = 0;
        end else begin
            m_age++;
            m_id = (m_base + m_age / SH) % 32;
        end
        m_auto = auto_en;
        m_edges++;
        #1;
        check_val("an", 32'(an), 32'(e_an));
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("dp", 32'(dp), 32'(e_dp));
        check_val("reg_out_id", 32'(reg_out_id), 32'(m_id));
    endtask

    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_an", 32'(an), 32'h0000_00FE);
        check_val("rst_seg", 32'(seg), 32'h0000_0040);
        check_val("rst_dp", 32'(dp), 32'h1);
        check_val("rst_id", 32'(reg_out_id), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        reset   = 1'b1;
        sel_id  = 5'd0;
        auto_en = 1'b0;
        #12;
        check_val("init_an", 32'(an), 32'h0000_00FE);
        check_val("init_seg", 32'(seg), 32'h0000_0040);
        check_val("init_dp", 32'(dp), 32'h1);
        check_val("init_id", 32'(reg_out_id), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Reset in the middle of a frame
        sel_id = 5'd17;
        for (int i = 0; i < 13; i++) step();
        mid_reset();

        // Manual select of r5
        sel_id   = 5'd5;
        regs[5]  = 32'h1234_ABCD;
        step();
        check_val("manual_latency", 32'(reg_out_id), 32'd5);
        for (int i = 0; i < 70; i++) step();

        // Data changes mid-frame only show after the next frame boundary
        for (int n = 0; n < 40 && ((m_edges / RD) % 8) != 3; n++) step();
        regs[5] = $urandom;
        for (int i = 0; i < 70; i++) step();

        // Auto scan starting from r30
        sel_id = 5'd30;
        step();
        step();
        auto_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 16) check_val("scan_before_wrap", 32'(reg_out_id), 32'd30);
            if (k == 17) check_val("scan_31", 32'(reg_out_id), 32'd31);
            if (k == 33) check_val("scan_wrap_0", 32'(reg_out_id), 32'd0);
            if (k == 49) check_val("scan_1", 32'(reg_out_id), 32'd1);
        end

        // Leave auto mode partway through a hold period
        for (int n = 0; n < 40 && (m_age % SH) != 10; n++) step();
        sel_id  = 5'd9;
        auto_en = 1'b0;
        step();
        check_val("manual_return", 32'(reg_out_id), 32'd9);
        for (int i = 0; i < 40; i++) step();
        check_val("manual_stays", 32'(reg_out_id), 32'd9);

        // Align hold terminal count with the frame capture edge
        for (int n = 0; n < 20 && (m_edges % SH) != SH - 1; n++) step();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        auto_en = 1'b1;
        for (int i = 0; i < 120; i++) step();
        auto_en = 1'b0;

        // Random traffic
        for (int i = 0; i < 1200; i++) begin
            step();
            if ($urandom_range(19) == 0) sel_id = 5'($urandom);
            if ($urandom_range(149) == 0) auto_en = ~auto_en;
            if ($urandom_range(7) == 0) regs[$urandom_range(31)] = $urandom;
            if (i == 600) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
